// File: rtl/gyro_angle_integrator_if.sv
// Sample/angle bus between the gyro front end, the integrator and the camera stage.
interface gyro_angle_integrator_if;
  logic               valid_in;
  logic signed [15:0] gx;
  logic signed [15:0] gy;
  logic signed [15:0] gz;
  logic               recal_in;
  logic        [8:0]  pitch;
  logic        [8:0]  roll;
  logic        [8:0]  yaw;
  logic               valid_out;
  logic               cal_done;

  modport master (
    output valid_in, gx, gy, gz, recal_in,
    input  pitch, roll, yaw, valid_out, cal_done
  );

  modport slave (
    input  valid_in, gx, gy, gz, recal_in,
    output pitch, roll, yaw, valid_out, cal_done
  );
endinterface

// File: rtl/gyro_angle_integrator.sv
// Gyro rate integrator: startup bias calibration, deadband, saturation and
// wrap-around angle accumulation for pitch/roll/yaw (one lane per axis).

// One axis: bias sum/capture, stage-1 correction, stage-2 wrapped accumulator.
module gyro_axis_lane #(
  parameter int CAL_LOG2  = 4,
  parameter int DEADBAND  = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               i_clr,       // entering CAL (reset or recal)
  input  logic               i_cal_acc,   // sample accepted while in CAL
  input  logic               i_cal_last,  // final calibration sample
  input  logic               i_run_acc,   // sample accepted while in RUN
  input  logic               i_s1_vld,    // stage-1 register holds a sample
  input  logic signed [15:0] i_g,
  output logic        [8:0]  o_angle
);
  localparam int                 SUM_W = 16 + CAL_LOG2;
  localparam logic signed [16:0] DB    = 17'(DEADBAND);
  localparam logic signed [17:0] MOD   = 18'(360 << FRAC_BITS);

  logic signed [SUM_W-1:0] r_sum;
  logic signed [SUM_W-1:0] w_sum_nxt;
  logic signed [15:0]      r_bias;
  logic signed [16:0]      w_corr;
  logic signed [16:0]      w_sat;
  logic signed [16:0]      w_db;
  logic signed [16:0]      r_s1;
  logic        [16:0]      r_acc;
  logic signed [17:0]      w_s;
  logic        [16:0]      w_acc_nxt;

  assign w_sum_nxt = r_sum + $signed({{CAL_LOG2{i_g[15]}}, i_g});

  // Stage-1 combinational path: bias removal, symmetric saturation, deadband.
  always_comb begin
    w_corr = $signed({i_g[15], i_g}) - $signed({r_bias[15], r_bias});
    w_sat  = w_corr;
    if (w_corr > 17'sd32767)       w_sat = 17'sd32767;
    else if (w_corr < -17'sd32767) w_sat = -17'sd32767;
    w_db = w_sat;
    if ((w_sat <= DB) && (w_sat >= -DB)) w_db = '0;
  end

  // Stage-2 combinational path: add and fold back into [0, 360 deg).
  always_comb begin
    w_s = $signed({1'b0, r_acc}) + $signed({r_s1[16], r_s1});
    if (w_s >= MOD)    w_acc_nxt = 17'(w_s - MOD);
    else if (w_s < 0)  w_acc_nxt = 17'(w_s + MOD);
    else               w_acc_nxt = 17'(w_s);
  end

  // Bias survives recal (only reset clears it); replaced at end of calibration.
  always_ff @(posedge clk_in) begin
    if (rst_in)          r_bias <= '0;
    else if (i_cal_last) r_bias <= 16'(w_sum_nxt >>> CAL_LOG2);
  end

  // Calibration sum, stage-1 register and accumulator; all cleared on entry to CAL.
  always_ff @(posedge clk_in) begin
    if (i_clr) begin
      r_sum <= '0;
      r_s1  <= '0;
      r_acc <= '0;
    end else begin
      if (i_cal_acc) r_sum <= w_sum_nxt;
      if (i_run_acc) r_s1  <= w_db;
      if (i_s1_vld)  r_acc <= w_acc_nxt;
    end
  end

  assign o_angle = r_acc[FRAC_BITS +: 9];
endmodule

// Top: calibration FSM, valid pipeline and the three axis lanes.
module gyro_angle_integrator #(
  parameter int CAL_LOG2  = 4,
  parameter int DEADBAND  = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  gyro_angle_integrator_if.slave  bus
);
  localparam int NUM_LANES = 3;

  typedef enum logic {S_CAL, S_RUN} state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [CAL_LOG2-1:0]            r_cnt;
  logic                           w_clr;
  logic                           w_accept;
  logic                           w_cal_acc;
  logic                           w_cal_last;
  logic                           w_run_acc;
  logic [2:1]                     r_vld_pipe;
  logic [NUM_LANES-1:0][15:0]     w_g;
  logic [NUM_LANES-1:0][8:0]      w_ang;

  // Recal beats a coincident sample; nothing is accepted during reset.
  assign w_clr      = rst_in | bus.recal_in;
  assign w_accept   = bus.valid_in & ~w_clr;
  assign w_cal_acc  = w_accept & (r_state == S_CAL);
  assign w_cal_last = w_cal_acc & (&r_cnt);
  assign w_run_acc  = w_accept & (r_state == S_RUN);

  // Next state: leave CAL on the last calibration sample, recal forces CAL.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CAL:   if (w_cal_last) w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_CAL;
    endcase
    if (bus.recal_in) w_state_nxt = S_CAL;
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= S_CAL;
    else        r_state <= w_state_nxt;
  end

  // Calibration sample counter; wraps to zero on the last sample.
  always_ff @(posedge clk_in) begin
    if (w_clr)          r_cnt <= '0;
    else if (w_cal_acc) r_cnt <= r_cnt + 1'b1;
  end

  // Valid shift register: [1] = stage-1 holds data, [2] = angles just updated.
  always_ff @(posedge clk_in) begin
    if (w_clr) r_vld_pipe <= '0;
    else       r_vld_pipe <= {r_vld_pipe[1], w_run_acc};
  end

  assign w_g = {bus.gz, bus.gy, bus.gx};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    gyro_axis_lane #(
      .CAL_LOG2  (CAL_LOG2),
      .DEADBAND  (DEADBAND),
      .FRAC_BITS (FRAC_BITS)
    ) u_lane (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .i_clr      (w_clr),
      .i_cal_acc  (w_cal_acc),
      .i_cal_last (w_cal_last),
      .i_run_acc  (w_run_acc),
      .i_s1_vld   (r_vld_pipe[1]),
      .i_g        (w_g[i]),
      .o_angle    (w_ang[i])
    );
  end

  assign bus.pitch     = w_ang[0];
  assign bus.roll      = w_ang[1];
  assign bus.yaw       = w_ang[2];
  assign bus.valid_out = r_vld_pipe[2];
  assign bus.cal_done  = (r_state == S_RUN);
endmodule

// File: tb/tb_gyro_angle_integrator.sv
// Directed bench for gyro_angle_integrator: calibration, wrap, deadband,
// saturation, recal and mid-stream reset with hand-computed angles.
module tb_gyro_angle_integrator;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  gyro_angle_integrator_if bus ();

  gyro_angle_integrator dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic signed [15:0] x,
                       input logic signed [15:0] y, input logic signed [15:0] z);
    bus.valid_in = v;
    bus.gx = x;
    bus.gy = y;
    bus.gz = z;
  endtask

  task automatic send(input logic signed [15:0] x, input logic signed [15:0] y,
                      input logic signed [15:0] z);
    drive(1'b1, x, y, z);
    tick();
    drive(1'b0, 16'sd0, 16'sd0, 16'sd0);
  endtask

  task automatic cal16(input logic signed [15:0] v);
    for (int i = 0; i < 16; i++) send(v, v, v);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    bus.recal_in = 1'b0;
    drive(1'b0, 16'sd0, 16'sd0, 16'sd0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.recal_in = 1'b0;
    drive(1'b0, 16'sd0, 16'sd0, 16'sd0);
    tick();
    tick();
    n_tests++;
    if ({bus.pitch, bus.roll, bus.yaw} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_angles got %0d/%0d/%0d want 0/0/0", bus.pitch, bus.roll, bus.yaw);
    end
    n_tests++;
    if ({bus.valid_out, bus.cal_done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_flags got vo=%0b cd=%0b want 0/0", bus.valid_out, bus.cal_done);
    end
    rst = 1'b0;
  endtask

  // 16 samples of 100 -> bias 100; then 10 back-to-back samples give 0 angles.
  task automatic test_cal;
    logic exp_vo;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 16'sd100, 16'sd100, 16'sd100);
      tick();
      n_tests++;
      if (bus.cal_done !== (i == 15)) begin
        n_fail++;
        $display("FAIL cal_done_timing sample %0d got %0b want %0b", i, bus.cal_done, (i == 15));
      end
    end
    for (int c = 0; c < 12; c++) begin
      drive(c < 10, 16'sd100, 16'sd100, 16'sd100);
      tick();
      exp_vo = (c >= 1) && (c <= 10);
      n_tests++;
      if (bus.valid_out !== exp_vo || {bus.pitch, bus.roll, bus.yaw} !== 27'd0) begin
        n_fail++;
        $display("FAIL cal_run cycle %0d got vo=%0b ang=%0d/%0d/%0d want vo=%0b ang=0/0/0",
                 c, bus.valid_out, bus.pitch, bus.roll, bus.yaw, exp_vo);
      end
    end
  endtask

  // 8 back-to-back 45-degree yaw steps: 45..315 then wrap to 0.
  task automatic test_yaw_wrap;
    logic       exp_vo;
    logic [8:0] exp_yaw;
    do_reset();
    cal16(16'sd0);
    exp_yaw = 9'd0;
    for (int c = 0; c < 10; c++) begin
      drive(c < 8, 16'sd0, 16'sd0, 16'sd11520);
      tick();
      exp_vo = (c >= 1) && (c <= 8);
      if (exp_vo) exp_yaw = 9'((45 * c) % 360);
      n_tests++;
      if (bus.valid_out !== exp_vo || bus.yaw !== exp_yaw || bus.pitch !== 9'd0) begin
        n_fail++;
        $display("FAIL yaw_wrap cycle %0d got vo=%0b yaw=%0d pitch=%0d want vo=%0b yaw=%0d pitch=0",
                 c, bus.valid_out, bus.yaw, bus.pitch, exp_vo, exp_yaw);
      end
    end
  endtask

  // -256 -> 359; +128 -> 359 (acc 92032); +128 -> 0 (acc 92160 wraps).
  task automatic test_neg_wrap;
    do_reset();
    cal16(16'sd0);
    send(-16'sd256, 16'sd0, 16'sd0);
    n_tests++;
    if (bus.valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early got vo=%0b want 0", bus.valid_out);
    end
    tick();
    n_tests++;
    if (bus.valid_out !== 1'b1 || bus.pitch !== 9'd359) begin
      n_fail++;
      $display("FAIL neg_wrap got vo=%0b pitch=%0d want 1/359", bus.valid_out, bus.pitch);
    end
    send(16'sd128, 16'sd0, 16'sd0);
    tick();
    n_tests++;
    if (bus.pitch !== 9'd359) begin
      n_fail++;
      $display("FAIL frac_half got pitch=%0d want 359", bus.pitch);
    end
    send(16'sd128, 16'sd0, 16'sd0);
    tick();
    n_tests++;
    if (bus.valid_out !== 1'b1 || bus.pitch !== 9'd0) begin
      n_fail++;
      $display("FAIL frac_wrap got vo=%0b pitch=%0d want 1/0", bus.valid_out, bus.pitch);
    end
    tick();
    n_tests++;
    if (bus.valid_out !== 1'b0 || bus.pitch !== 9'd0) begin
      n_fail++;
      $display("FAIL hold got vo=%0b pitch=%0d want 0/0", bus.valid_out, bus.pitch);
    end
  endtask

  // 16 x 16 stays in the deadband; 16 x 17 reaches acc 272 -> roll 1; -16 ignored.
  task automatic test_deadband;
    do_reset();
    cal16(16'sd0);
    for (int i = 0; i < 16; i++) send(16'sd0, 16'sd16, 16'sd0);
    tick();
    n_tests++;
    if (bus.valid_out !== 1'b1 || bus.roll !== 9'd0) begin
      n_fail++;
      $display("FAIL deadband_edge got vo=%0b roll=%0d want 1/0", bus.valid_out, bus.roll);
    end
    for (int i = 0; i < 16; i++) send(16'sd0, 16'sd17, 16'sd0);
    tick();
    n_tests++;
    if (bus.roll !== 9'd1) begin
      n_fail++;
      $display("FAIL deadband_above got roll=%0d want 1", bus.roll);
    end
    for (int i = 0; i < 16; i++) send(16'sd0, -16'sd16, 16'sd0);
    tick();
    n_tests++;
    if (bus.roll !== 9'd1) begin
      n_fail++;
      $display("FAIL deadband_neg got roll=%0d want 1", bus.roll);
    end
  endtask

  // Bias -32768, gy = 32767 -> corrected 65535 saturates to 32767 -> roll 127.
  task automatic test_saturation;
    do_reset();
    cal16(-16'sd32768);
    send(-16'sd32768, 16'sd32767, -16'sd32768);
    tick();
    n_tests++;
    if (bus.valid_out !== 1'b1 || bus.roll !== 9'd127 || bus.pitch !== 9'd0 || bus.yaw !== 9'd0) begin
      n_fail++;
      $display("FAIL saturation got vo=%0b ang=%0d/%0d/%0d want 1 0/127/0",
               bus.valid_out, bus.pitch, bus.roll, bus.yaw);
    end
  endtask

  // Recal with a coincident sample and one in flight; then recalibrate to -40.
  task automatic test_recal;
    do_reset();
    cal16(16'sd0);
    send(16'sd0, 16'sd0, 16'sd11520);
    send(16'sd0, 16'sd0, 16'sd11520);
    tick();
    tick();
    n_tests++;
    if (bus.yaw !== 9'd90) begin
      n_fail++;
      $display("FAIL recal_pre got yaw=%0d want 90", bus.yaw);
    end
    send(16'sd0, 16'sd0, 16'sd11520);
    drive(1'b1, 16'sd0, 16'sd0, 16'sd11520);
    bus.recal_in = 1'b1;
    tick();
    bus.recal_in = 1'b0;
    drive(1'b0, 16'sd0, 16'sd0, 16'sd0);
    n_tests++;
    if (bus.cal_done !== 1'b0 || bus.yaw !== 9'd0 || bus.valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL recal_clear got cd=%0b yaw=%0d vo=%0b want 0/0/0",
               bus.cal_done, bus.yaw, bus.valid_out);
    end
    tick();
    n_tests++;
    if (bus.valid_out !== 1'b0 || bus.yaw !== 9'd0) begin
      n_fail++;
      $display("FAIL recal_drop got vo=%0b yaw=%0d want 0/0", bus.valid_out, bus.yaw);
    end
    for (int i = 0; i < 16; i++) begin
      send(-16'sd40, -16'sd40, -16'sd40);
      n_tests++;
      if (bus.cal_done !== (i == 15)) begin
        n_fail++;
        $display("FAIL recal_count sample %0d got cd=%0b want %0b", i, bus.cal_done, (i == 15));
      end
    end
    send(-16'sd40, -16'sd40, -16'sd40);
    tick();
    n_tests++;
    if (bus.valid_out !== 1'b1 || {bus.pitch, bus.roll, bus.yaw} !== 27'd0) begin
      n_fail++;
      $display("FAIL recal_bias got vo=%0b ang=%0d/%0d/%0d want 1 0/0/0",
               bus.valid_out, bus.pitch, bus.roll, bus.yaw);
    end
  endtask

  // Reset the cycle after a RUN sample (with valid held during reset).
  task automatic test_reset_mid;
    send(16'sd0, 16'sd0, 16'sd11520);
    rst = 1'b1;
    drive(1'b1, 16'sd0, 16'sd0, 16'sd11520);
    tick();
    rst = 1'b0;
    drive(1'b0, 16'sd0, 16'sd0, 16'sd0);
    n_tests++;
    if ({bus.pitch, bus.roll, bus.yaw} !== 27'd0 || bus.valid_out !== 1'b0 || bus.cal_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid got ang=%0d/%0d/%0d vo=%0b cd=%0b want 0/0/0 0 0",
               bus.pitch, bus.roll, bus.yaw, bus.valid_out, bus.cal_done);
    end
    tick();
    n_tests++;
    if (bus.valid_out !== 1'b0 || bus.yaw !== 9'd0) begin
      n_fail++;
      $display("FAIL rst_mid_drop got vo=%0b yaw=%0d want 0/0", bus.valid_out, bus.yaw);
    end
    for (int i = 0; i < 16; i++) begin
      send(16'sd0, 16'sd0, 16'sd0);
      n_tests++;
      if (bus.cal_done !== (i == 15)) begin
        n_fail++;
        $display("FAIL rst_mid_count sample %0d got cd=%0b want %0b", i, bus.cal_done, (i == 15));
      end
    end
    send(16'sd0, 16'sd0, 16'sd256);
    tick();
    n_tests++;
    if (bus.valid_out !== 1'b1 || bus.yaw !== 9'd1) begin
      n_fail++;
      $display("FAIL rst_mid_run got vo=%0b yaw=%0d want 1/1", bus.valid_out, bus.yaw);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.recal_in = 1'b0;
    drive(1'b0, 16'sd0, 16'sd0, 16'sd0);
    test_reset();
    test_cal();
    test_yaw_wrap();
    test_neg_wrap();
    test_deadband();
    test_saturation();
    test_recal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
